// File: rtl/upcounter_sync.sv
// Synchronous modulo-N up counter with clear, parallel load, enable gating,
// wrap-or-saturate mode, a one-cycle wrap pulse and a sticky overflow flag.
module upcounter_sync #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             wrapped,
    output logic             overflow
);

    localparam logic [WIDTH:0]   MOD_FULL = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP      = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $fatal(1, "upcounter_sync: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end

    logic [WIDTH:0] count_inc;
    logic           at_top;
    logic           load_oor;
    logic           step;
    logic           ovf_set;
    logic           sat_hold;

    // The increment carries into bit WIDTH, so the top test also works when
    // MODULUS equals 2**WIDTH and the count wraps by natural binary rollover.
    assign count_inc = {1'b0, count} + (WIDTH+1)'(1);
    assign at_top    = (count_inc == MOD_FULL);
    assign load_oor  = ({1'b0, load_value} >= MOD_FULL);
    assign step      = enable && !clear && !load;
    assign carry     = step && at_top;
    assign ovf_set   = carry || (load && !clear && load_oor);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            wrapped  <= 1'b0;
            overflow <= 1'b0;
            sat_hold <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end

            if (clear) begin
                count    <= '0;
                wrapped  <= 1'b0;
                sat_hold <= 1'b0;
            end else if (load) begin
                count    <= load_oor ? TOP : load_value;
                wrapped  <= 1'b0;
                sat_hold <= 1'b0;
            end else if (enable) begin
                if (!at_top) begin
                    count    <= count_inc[WIDTH-1:0];
                    wrapped  <= 1'b0;
                    sat_hold <= 1'b0;
                end else if (SATURATE != 0) begin
                    // sat_hold remembers that this stay at the top already pulsed
                    wrapped  <= !sat_hold;
                    sat_hold <= 1'b1;
                end else begin
                    count   <= '0;
                    wrapped <= 1'b1;
                end
            end else begin
                wrapped <= 1'b0;
            end
        end
    end

endmodule

// File: doc/upcounter_sync.md
Name: upcounter_sync

Overview:
- Synchronous modulo-N up counter; the counting-up counterpart of the team's 4-bit synchronous down counter.
- Intended for timebases, event counting and cascaded BCD/decade chains: `carry` feeds the `enable` of the next stage.
- Adds synchronous clear, parallel load, enable gating, wrap-or-saturate mode and a sticky overflow flag.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- SATURATE, 0, 0 = wrap MODULUS-1 -> 0; 1 = hold at MODULUS-1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  count-advance qualifier.
- clear  input  1  synchronous clear of count.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value to load.
- clear_ovf  input  1  synchronous clear of the overflow flag.
- count  output  WIDTH  current count (registered).
- carry  output  1  combinational: enable && count==MODULUS-1 && !clear && !load.
- wrapped  output  1  registered 1-cycle pulse, high the cycle after a wrap or saturation-hit event.
- overflow  output  1  sticky flag.

Behaviour:
- Interface: one clock, `clock`; `reset` is asynchronous and active-high. While reset=1: count=0, wrapped=0, overflow=0, all immediately, with no clock edge needed.
- Reset release: the first active edge after reset falls evaluates inputs normally.
- Per-edge priority: reset > clear > load > enable > hold.
- clear=1: count<=0 and wrapped<=0. overflow is unaffected; clear_ovf still applies.
- load=1 (clear=0):
  - load_value < MODULUS: count<=load_value.
  - load_value >= MODULUS: count<=MODULUS-1 and overflow<=1.
  - wrapped<=0.
- enable=1 (clear=0, load=0):
  - count < MODULUS-1: count<=count+1, wrapped<=0.
  - count==MODULUS-1 and SATURATE=0: count<=0, wrapped<=1, overflow<=1.
  - count==MODULUS-1 and SATURATE=1: count holds, wrapped<=1 only on the first enabled cycle at MODULUS-1 (edge-detected), overflow<=1.
- enable=0 and no clear/load: count holds, wrapped<=0.
- clear_ovf=1: overflow<=0, unless an overflow-setting event occurs on the same edge. Setting wins.
- Latency:
  - count updates 1 cycle after the qualifying edge.
  - carry is same-cycle combinational and usable as the next stage's enable, giving a zero-cycle ripple between cascaded stages.
  - wrapped lags count by 0 cycles: it updates on the same edge as the wrap.
- Arithmetic: the increment is computed at WIDTH+1 bits; the MODULUS compare uses the unsigned full value. No X-propagation from an out-of-range count.
- MODULUS==2^WIDTH: the wrap equals natural binary rollover. Behaviour is identical to the rules above.
- Illegal MODULUS (<2 or >2^WIDTH): an elaboration-time check halts simulation with an error.
- Reset mid-count: count returns to 0 asynchronously. A pending load/clear on that edge is discarded.

Test Plan:
- WIDTH=4, MODULUS=10, SATURATE=0. Reset 20 ns, then enable=1 for 12 clocks -> count 1..9,0,1,2; carry high only while count==9; wrapped pulses once, in the cycle count==0; overflow=1.
- Same config, count==5. Drive load=1, load_value=7 together with enable=1 -> count=7 next cycle (load beats enable). Then load_value=12 -> count=9, overflow=1.
- SATURATE=1, MODULUS=10. enable=1 for 15 clocks -> count sticks at 9; wrapped is a single 1-cycle pulse; carry stays high while enable=1.
- count==9, enable=1, clear=1 on the same edge -> count=0, wrapped=0, carry=0. Then clear_ovf=1 coinciding with a wrap -> overflow remains 1. clear_ovf alone -> overflow=0.
- Assert reset asynchronously between edges at count==6 -> count=0 immediately. Enable=0 for 3 clocks -> count holds at 0.
- Two instances cascaded (MODULUS=10 each; stage-1 enable = stage-0 carry). 100 enabled clocks -> {tens,ones} goes 00..99 then wraps to 00; stage-1 overflow=1.
